// File: rtl/spi_fifo_tx.sv
// spi_fifo_tx: drains a FWFT FIFO (fifo_data/fifo_empty in, fifo_pull out) onto a mode-0 write-only SPI link (spi_sclk/spi_mosi/spi_cs_n/spi_dc out) with busy status
module spi_fifo_tx #(
  parameter int WIDTH   = 9,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_pull,
  output logic             spi_sclk,
  output logic             spi_mosi,
  output logic             spi_cs_n,
  output logic             spi_dc,
  output logic             busy
);
  localparam int N = WIDTH - 1;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = N > 1 ? $clog2(N) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(N - 1);
  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;
  state_t state, state_nx;
  logic [DW-1:0] div, div_nx;
  logic [BW-1:0] bit_cnt, bit_nx;
  logic [N-1:0] shreg, shreg_nx;
  logic sclk_nx, cs_nx, dc_nx;
  logic div_end, last;
  assign div_end = div == DIV_MAX;
  assign last = bit_cnt == BIT_MAX;
  assign fifo_pull = !rst && !fifo_empty &&
                     (state == IDLE || (state == SHIFT_HI && div_end && last));
  assign busy = state != IDLE;
  assign spi_mosi = shreg[N-1];
  always_comb begin
    state_nx = state;
    div_nx = div_end ? '0 : div + 1'b1;
    bit_nx = bit_cnt;
    shreg_nx = shreg;
    sclk_nx = spi_sclk;
    cs_nx = spi_cs_n;
    dc_nx = spi_dc;
    case (state)
      IDLE: div_nx = '0;
      SHIFT_LO: if (div_end) begin
        sclk_nx = 1'b1;
        state_nx = SHIFT_HI;
      end
      SHIFT_HI: if (div_end) begin
        sclk_nx = 1'b0;
        if (!last) begin
          shreg_nx = shreg << 1;
          bit_nx = bit_cnt + 1'b1;
          state_nx = SHIFT_LO;
        end else if (fifo_empty) begin
          shreg_nx = '0;
          state_nx = HOLD;
        end
      end
      HOLD: if (div_end) begin
        cs_nx = 1'b1;
        state_nx = GAP;
      end
      GAP: if (div_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // a pull (from IDLE or at the last bit's falling edge) always starts a fresh word
    if (fifo_pull) begin
      shreg_nx = fifo_data[N-1:0];
      dc_nx = fifo_data[WIDTH-1];
      cs_nx = 1'b0;
      sclk_nx = 1'b0;
      bit_nx = '0;
      div_nx = '0;
      state_nx = SHIFT_LO;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      div <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      spi_sclk <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_dc <= 1'b0;
    end else begin
      state <= state_nx;
      div <= div_nx;
      bit_cnt <= bit_nx;
      shreg <= shreg_nx;
      spi_sclk <= sclk_nx;
      spi_cs_n <= cs_nx;
      spi_dc <= dc_nx;
    end
  end
endmodule

// File: doc/spi_fifo_tx.md
# spi_fifo_tx

Drains a first-word-fall-through FIFO (valid word visible on the read data whenever not empty, advanced by a one-cycle pull) and transmits each word over a write-only SPI link in mode 0 (CPOL=0, CPHA=0), MSB first, with a per-word data/command flag. It sits at the consumer end of the display command/pixel FIFO and drives the LCD controller pins. Back-to-back words stream without deasserting chip select. Chip select is released only when the FIFO runs dry.

## Interface
- WIDTH, 9: FIFO word width. Bit WIDTH-1 is the DC flag; bits WIDTH-2:0 are shifted out (N = WIDTH-1 bits per word, N ≥ 1).
- CLK_DIV, 2: SCLK half-period in clk cycles, ≥ 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- fifo_data  in  WIDTH  FIFO head word, valid while fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_pull  out  1  combinational; consume head word at this clock edge.
- spi_sclk  out  1  serial clock, registered.
- spi_mosi  out  1  serial data, registered (shift register MSB).
- spi_cs_n  out  1  chip select, active low, registered.
- spi_dc  out  1  data/command flag of current word, registered.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP. Internal signals: div counter (0..CLK_DIV-1), bit counter (0..N-1), N-bit shift register.
- fifo_pull = !rst && !fifo_empty && (state==IDLE || (state==SHIFT_HI && div==CLK_DIV-1 && bit==N-1)). It is never asserted while fifo_empty=1.
- Load on a pull edge: shreg ← fifo_data[WIDTH-2:0], spi_dc ← fifo_data[WIDTH-1], spi_cs_n ← 0, spi_sclk ← 0, bit ← 0, div ← 0, state → SHIFT_LO.
- SHIFT_LO: sclk=0 for CLK_DIV cycles. Then sclk ← 1 and state → SHIFT_HI. The rising edge samples mosi.
- SHIFT_HI: sclk=1 for CLK_DIV cycles. At the end of the phase, sclk ← 0 and then:
  - Bit not last: shreg shifts left with 0 fill, bit++, state → SHIFT_LO.
  - Last bit, fifo_empty=0: load the next word (as above) with cs_n held low.
  - Last bit, fifo_empty=1: shreg ← 0 (mosi=0), state → HOLD.
- HOLD: cs_n=0, sclk=0 for CLK_DIV cycles. Then cs_n ← 1, state → GAP. A word arriving during HOLD is not pulled until IDLE.
- GAP: cs_n=1 for CLK_DIV cycles, then state → IDLE. This guarantees a minimum CS-high time.
- spi_dc changes only at load edges and otherwise holds its value, including through IDLE.
- Reset values: spi_sclk=0, spi_mosi=0, spi_cs_n=1, spi_dc=0, busy=0, fifo_pull=0, state=IDLE, counters=0.
- Reset mid-word: the next edge forces all reset values. The partial word is lost and is not re-pulled.

## Timing
- IDLE to first SCLK rise: pull cycle + CLK_DIV cycles. The first MSB is on mosi for CLK_DIV cycles before the rise.
- Per bit: 2·CLK_DIV cycles. Per word: 2·N·CLK_DIV cycles. Streaming has zero extra cycles between words.
- Word end to cs_n high: CLK_DIV cycles (HOLD). cs_n high to next possible pull: CLK_DIV cycles (GAP) + 1 IDLE cycle.
- mosi and dc change only on SCLK falling edges or while SCLK is low, giving CLK_DIV cycles of setup before each rise.

## Test plan
- Reset check: after rst, observe cs_n=1, sclk=0, mosi=0, dc=0, busy=0, and fifo_pull=0 with a non-empty FIFO held during rst.
- Single word, CLK_DIV=2: push 9'h1A5. Require exactly one pull, dc=1, 8 SCLK rises sampling 1,0,1,0,0,1,0,1, and cs_n low for 34 cycles total (32 shift + 2 HOLD).
- Streaming: three words 9'h0FF, 9'h100, 9'h055 present at start. Require 24 contiguous rises with uniform 4-cycle period, cs_n low throughout, and dc sequence 0,1,0 switching only while sclk=0.
- Underrun: push a second word 1 cycle after the first word's HOLD begins. Require cs_n to go high, stay high ≥ 2 cycles (GAP), then a new transaction starts.
- Reset mid-word: assert rst after 3 rises. Next edge must show cs_n=1, sclk=0, busy=0. Pull count stays 1, and the next FIFO word transmits cleanly after rst drops.
- CLK_DIV=1, WIDTH=2: a 1-bit word stream of alternating 2'b01/2'b00 yields a 2-cycle SCLK period and mosi 1,0,1,0…
